// File: rtl/tlb_op_ctrl.sv
// TLB-maintenance sequencer: runs TLBR/TLBWI/TLBWR/TLBP through a fixed
// IDLE -> ACCESS -> RESP sequence. It also owns the Random/Wired pair used to
// pick the TLBWR victim entry.
//
// state  | meaning
// IDLE   | ready for a new op; request operands latched on acceptance
// ACCESS | TLB write strobe, read index or search key driven; results captured
// RESP   | completion pulse, CP0 write-back and flush request
module tlb_op_ctrl #(
    parameter int TLBNUM    = 16,
    parameter int IDXW      = $clog2(TLBNUM),
    parameter int WIRED_RST = 0
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [1:0]      req_op,
    input  logic [31:0]     req_pc,
    input  logic [31:0]     cp0_entryhi,
    input  logic [31:0]     cp0_entrylo0,
    input  logic [31:0]     cp0_entrylo1,
    input  logic [31:0]     cp0_index,
    input  logic            wired_we,
    input  logic [IDXW-1:0] wired_wdata,
    output logic            tlb_we,
    output logic [IDXW-1:0] tlb_w_index,
    output logic [26:0]     tlb_w_hi,
    output logic            tlb_w_g,
    output logic [24:0]     tlb_w_lo0,
    output logic [24:0]     tlb_w_lo1,
    output logic [IDXW-1:0] tlb_r_index,
    input  logic [26:0]     tlb_r_hi,
    input  logic            tlb_r_g,
    input  logic [24:0]     tlb_r_lo0,
    input  logic [24:0]     tlb_r_lo1,
    output logic [18:0]     tlb_s_vpn2,
    output logic [7:0]      tlb_s_asid,
    input  logic            tlb_s_found,
    input  logic [IDXW-1:0] tlb_s_index,
    output logic            rsp_valid,
    output logic            hi_lo_we,
    output logic            index_we,
    output logic [31:0]     entryhi_wdata,
    output logic [31:0]     entrylo0_wdata,
    output logic [31:0]     entrylo1_wdata,
    output logic [31:0]     index_wdata,
    output logic            flush_valid,
    output logic [31:0]     flush_pc,
    output logic [IDXW-1:0] cp0_random,
    output logic [IDXW-1:0] cp0_wired
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_RESP   = 2'd2;

    localparam logic [1:0] OP_TLBR  = 2'd0;
    localparam logic [1:0] OP_TLBWI = 2'd1;
    localparam logic [1:0] OP_TLBWR = 2'd2;
    localparam logic [1:0] OP_TLBP  = 2'd3;

    localparam logic [IDXW-1:0] RND_MAX   = IDXW'(TLBNUM - 1);
    localparam logic [IDXW-1:0] WIRED_INI = IDXW'(WIRED_RST);

    logic [1:0]      state;
    logic [1:0]      op_q;
    logic [31:0]     pc_q;
    logic [18:0]     vpn2_q;
    logic [7:0]      asid_q;
    logic [24:0]     lo0_q;
    logic [24:0]     lo1_q;
    logic            g_q;
    logic [IDXW-1:0] index_q;
    logic [IDXW-1:0] rnd_q;
    logic [26:0]     r_hi_q;
    logic            r_g_q;
    logic [24:0]     r_lo0_q;
    logic [24:0]     r_lo1_q;
    logic            s_found_q;
    logic [IDXW-1:0] s_index_q;
    logic [IDXW-1:0] random_q;
    logic [IDXW-1:0] wired_q;
    logic            accept;
    logic            unused_bits;

    // CP0 fields that the TLB datapath never looks at
    assign unused_bits = ^{cp0_entryhi[12:8], cp0_entrylo0[31:26],
                           cp0_entrylo1[31:26], cp0_index[31:IDXW]};

    assign accept = req_valid && (state == S_IDLE);

    // Sequencer: one op per three cycles, no stalls
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= S_IDLE;
        end else begin
            case (state)
                S_IDLE:   if (accept) state <= S_ACCESS;
                S_ACCESS: state <= S_RESP;
                default:  state <= S_IDLE;
            endcase
        end
    end

    // Operand capture on acceptance; Random is sampled before any Wired update
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            op_q    <= OP_TLBR;
            pc_q    <= '0;
            vpn2_q  <= '0;
            asid_q  <= '0;
            lo0_q   <= '0;
            lo1_q   <= '0;
            g_q     <= 1'b0;
            index_q <= '0;
            rnd_q   <= '0;
        end else if (accept) begin
            op_q    <= req_op;
            pc_q    <= req_pc;
            vpn2_q  <= cp0_entryhi[31:13];
            asid_q  <= cp0_entryhi[7:0];
            lo0_q   <= cp0_entrylo0[25:1];
            lo1_q   <= cp0_entrylo1[25:1];
            g_q     <= cp0_entrylo0[0] & cp0_entrylo1[0];
            index_q <= cp0_index[IDXW-1:0];
            rnd_q   <= random_q;
        end
    end

    // TLB read and search results are captured at the end of ACCESS
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_hi_q    <= '0;
            r_g_q     <= 1'b0;
            r_lo0_q   <= '0;
            r_lo1_q   <= '0;
            s_found_q <= 1'b0;
            s_index_q <= '0;
        end else if (state == S_ACCESS) begin
            r_hi_q    <= tlb_r_hi;
            r_g_q     <= tlb_r_g;
            r_lo0_q   <= tlb_r_lo0;
            r_lo1_q   <= tlb_r_lo1;
            s_found_q <= tlb_s_found;
            s_index_q <= tlb_s_index;
        end
    end

    // Random counts down to Wired then wraps to the top entry; Wired writes restart it
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            random_q <= RND_MAX;
            wired_q  <= WIRED_INI;
        end else if (wired_we) begin
            random_q <= RND_MAX;
            wired_q  <= wired_wdata;
        end else if ((random_q == wired_q) || (wired_q >= RND_MAX)) begin
            random_q <= RND_MAX;
        end else begin
            random_q <= random_q - 1'b1;
        end
    end

    // Output decode from the state register and the captured operands
    always_comb begin
        req_ready      = (state == S_IDLE);
        tlb_we         = (state == S_ACCESS) && ((op_q == OP_TLBWI) || (op_q == OP_TLBWR));
        tlb_w_index    = (op_q == OP_TLBWR) ? rnd_q : index_q;
        tlb_w_hi       = {vpn2_q, asid_q};
        tlb_w_g        = g_q;
        tlb_w_lo0      = lo0_q;
        tlb_w_lo1      = lo1_q;
        tlb_r_index    = index_q;
        tlb_s_vpn2     = vpn2_q;
        tlb_s_asid     = asid_q;
        rsp_valid      = (state == S_RESP);
        hi_lo_we       = rsp_valid && (op_q == OP_TLBR);
        index_we       = rsp_valid && (op_q == OP_TLBP);
        flush_valid    = rsp_valid && (op_q != OP_TLBP);
        flush_pc       = flush_valid ? (pc_q + 32'd4) : 32'd0;
        entryhi_wdata  = 32'd0;
        entrylo0_wdata = 32'd0;
        entrylo1_wdata = 32'd0;
        index_wdata    = 32'd0;
        if (hi_lo_we) begin
            entryhi_wdata  = {r_hi_q[26:8], 5'b0, r_hi_q[7:0]};
            entrylo0_wdata = {6'b0, r_lo0_q, r_g_q};
            entrylo1_wdata = {6'b0, r_lo1_q, r_g_q};
        end
        if (index_we) begin
            index_wdata = s_found_q ? {{(32-IDXW){1'b0}}, s_index_q} : 32'h8000_0000;
        end
        cp0_random     = random_q;
        cp0_wired      = wired_q;
    end

endmodule

// File: tb/tb_tlb_op_ctrl.sv
// Bench for tlb_op_ctrl with TLBNUM=16: a vector table of ops with hand-derived
// expected results, a response scoreboard, and hand sequences for the
// Random/Wired and reset-in-flight cases.
module tb_tlb_op_ctrl;

    logic        clk;
    logic        resetn;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [31:0] req_pc;
    logic [31:0] cp0_entryhi, cp0_entrylo0, cp0_entrylo1, cp0_index;
    logic        wired_we;
    logic [3:0]  wired_wdata;
    logic        tlb_we;
    logic [3:0]  tlb_w_index;
    logic [26:0] tlb_w_hi;
    logic        tlb_w_g;
    logic [24:0] tlb_w_lo0, tlb_w_lo1;
    logic [3:0]  tlb_r_index;
    logic [26:0] tlb_r_hi;
    logic        tlb_r_g;
    logic [24:0] tlb_r_lo0, tlb_r_lo1;
    logic [18:0] tlb_s_vpn2;
    logic [7:0]  tlb_s_asid;
    logic        tlb_s_found;
    logic [3:0]  tlb_s_index;
    logic        rsp_valid, hi_lo_we, index_we;
    logic [31:0] entryhi_wdata, entrylo0_wdata, entrylo1_wdata, index_wdata;
    logic        flush_valid;
    logic [31:0] flush_pc;
    logic [3:0]  cp0_random, cp0_wired;

    tlb_op_ctrl #(.TLBNUM(16), .IDXW(4), .WIRED_RST(0)) dut (
        .clk(clk), .resetn(resetn),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_pc(req_pc),
        .cp0_entryhi(cp0_entryhi), .cp0_entrylo0(cp0_entrylo0),
        .cp0_entrylo1(cp0_entrylo1), .cp0_index(cp0_index),
        .wired_we(wired_we), .wired_wdata(wired_wdata),
        .tlb_we(tlb_we), .tlb_w_index(tlb_w_index), .tlb_w_hi(tlb_w_hi), .tlb_w_g(tlb_w_g),
        .tlb_w_lo0(tlb_w_lo0), .tlb_w_lo1(tlb_w_lo1),
        .tlb_r_index(tlb_r_index), .tlb_r_hi(tlb_r_hi), .tlb_r_g(tlb_r_g),
        .tlb_r_lo0(tlb_r_lo0), .tlb_r_lo1(tlb_r_lo1),
        .tlb_s_vpn2(tlb_s_vpn2), .tlb_s_asid(tlb_s_asid),
        .tlb_s_found(tlb_s_found), .tlb_s_index(tlb_s_index),
        .rsp_valid(rsp_valid), .hi_lo_we(hi_lo_we), .index_we(index_we),
        .entryhi_wdata(entryhi_wdata), .entrylo0_wdata(entrylo0_wdata),
        .entrylo1_wdata(entrylo1_wdata), .index_wdata(index_wdata),
        .flush_valid(flush_valid), .flush_pc(flush_pc),
        .cp0_random(cp0_random), .cp0_wired(cp0_wired)
    );

    typedef struct packed {
        // stimulus and TLB model response
        logic [1:0]  op;
        logic [31:0] pc, hi, lo0, lo1, idx;
        logic [26:0] r_hi;
        logic        r_g;
        logic [24:0] r_lo0, r_lo1;
        logic        s_found;
        logic [3:0]  s_idx;
        // expected ACCESS-cycle outputs
        logic        we;
        logic [3:0]  w_index;
        logic [26:0] w_hi;
        logic        w_g;
        logic [24:0] w_lo0, w_lo1;
        logic [3:0]  r_index;
        logic [18:0] vpn2;
        logic [7:0]  asid;
        // expected RESP-cycle outputs
        logic        hilo_we, idx_we, flush;
        logic [31:0] eh, el0, el1, iw, fpc;
    } vec_t;

    vec_t tbl[$];
    vec_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic issue(input vec_t v);
        int n = 0;
        while (!req_ready && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("req_ready_before_issue", {31'd0, req_ready}, 32'd1);
        req_valid    = 1'b1;
        req_op       = v.op;
        req_pc       = v.pc;
        cp0_entryhi  = v.hi;
        cp0_entrylo0 = v.lo0;
        cp0_entrylo1 = v.lo1;
        cp0_index    = v.idx;
        tlb_r_hi     = v.r_hi;
        tlb_r_g      = v.r_g;
        tlb_r_lo0    = v.r_lo0;
        tlb_r_lo1    = v.r_lo1;
        tlb_s_found  = v.s_found;
        tlb_s_index  = v.s_idx;
        sb.push_back(v);
    endtask

    task automatic finish_op();
        vec_t e;
        int   n;
        @(negedge clk);
        req_valid = 1'b0;
        wired_we  = 1'b0;
        e = sb[0];
        chk("acc_tlb_we", {31'd0, tlb_we}, {31'd0, e.we});
        if (e.we) begin
            chk("acc_w_index", {28'd0, tlb_w_index}, {28'd0, e.w_index});
            chk("acc_w_hi",    {5'd0, tlb_w_hi},     {5'd0, e.w_hi});
            chk("acc_w_g",     {31'd0, tlb_w_g},     {31'd0, e.w_g});
            chk("acc_w_lo0",   {7'd0, tlb_w_lo0},    {7'd0, e.w_lo0});
            chk("acc_w_lo1",   {7'd0, tlb_w_lo1},    {7'd0, e.w_lo1});
        end else if (e.op == 2'd0) begin
            chk("acc_r_index", {28'd0, tlb_r_index}, {28'd0, e.r_index});
        end else begin
            chk("acc_s_vpn2", {13'd0, tlb_s_vpn2}, {13'd0, e.vpn2});
            chk("acc_s_asid", {24'd0, tlb_s_asid}, {24'd0, e.asid});
        end
        chk("acc_no_rsp", {31'd0, rsp_valid}, 32'd0);
        @(negedge clk);
        n = 0;
        while (!rsp_valid && n < 4) begin
            @(negedge clk);
            n++;
        end
        chk("rsp_latency", n, 0);
        e = sb.pop_front();
        if (rsp_valid) begin
            chk("rsp_hi_lo_we",   {31'd0, hi_lo_we},    {31'd0, e.hilo_we});
            chk("rsp_index_we",   {31'd0, index_we},    {31'd0, e.idx_we});
            chk("rsp_flush",      {31'd0, flush_valid}, {31'd0, e.flush});
            chk("rsp_flush_pc",   flush_pc,       e.fpc);
            chk("rsp_entryhi",    entryhi_wdata,  e.eh);
            chk("rsp_entrylo0",   entrylo0_wdata, e.el0);
            chk("rsp_entrylo1",   entrylo1_wdata, e.el1);
            chk("rsp_index",      index_wdata,    e.iw);
        end else begin
            chk("rsp_timeout", 32'd0, 32'd1);
        end
        @(negedge clk);
        chk("req_ready_cycle3", {31'd0, req_ready}, 32'd1);
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_tlb_we"},   {31'd0, tlb_we},      32'd0);
        chk({tag, "_rsp"},      {31'd0, rsp_valid},   32'd0);
        chk({tag, "_flush"},    {31'd0, flush_valid}, 32'd0);
        chk({tag, "_flush_pc"}, flush_pc,             32'd0);
        chk({tag, "_index_wd"}, index_wdata,          32'd0);
    endtask

    initial begin
        vec_t v;
        vec_t wr;
        logic [3:0] model;
        int n;

        // TLBWI, all-ones-global entry
        v = '0; v.op = 2'd1; v.pc = 32'hBFC0_0100; v.hi = 32'h1234_A0FF;
        v.lo0 = 32'h0000_0047; v.lo1 = 32'h0000_0087; v.idx = 32'd5;
        v.we = 1'b1; v.w_index = 4'd5; v.w_hi = {19'h091A5, 8'hFF}; v.w_g = 1'b1;
        v.w_lo0 = 25'h23; v.w_lo1 = 25'h43; v.flush = 1'b1; v.fpc = 32'hBFC0_0104;
        tbl.push_back(v);
        // TLBP miss
        v = '0; v.op = 2'd3; v.pc = 32'h0000_0040; v.hi = 32'h0000_4023; v.s_found = 1'b0;
        v.s_idx = 4'd7; v.vpn2 = 19'd2; v.asid = 8'h23; v.idx_we = 1'b1; v.iw = 32'h8000_0000;
        tbl.push_back(v);
        // TLBP hit at 9
        v = '0; v.op = 2'd3; v.pc = 32'h0000_0080; v.hi = 32'hFFFF_E0AB; v.s_found = 1'b1;
        v.s_idx = 4'd9; v.vpn2 = 19'h7FFFF; v.asid = 8'hAB; v.idx_we = 1'b1; v.iw = 32'd9;
        tbl.push_back(v);
        // TLBR at 3
        v = '0; v.op = 2'd0; v.pc = 32'h0000_1000; v.idx = 32'd3;
        v.r_hi = {19'h7, 8'h2}; v.r_g = 1'b1; v.r_lo0 = 25'h12345; v.r_lo1 = 25'h00ABC;
        v.r_index = 4'd3; v.hilo_we = 1'b1; v.eh = 32'h0000_E002; v.el0 = 32'h0002_468B;
        v.el1 = 32'h0000_1579; v.flush = 1'b1; v.fpc = 32'h0000_1004;
        tbl.push_back(v);
        // TLBWI: non-global, top index, Index upper bits ignored, PC wraps
        v = '0; v.op = 2'd1; v.pc = 32'hFFFF_FFFC; v.hi = 32'hFFFF_FFFF;
        v.lo0 = 32'h03FF_FFFF; v.lo1 = 32'h0000_0002; v.idx = 32'hFFFF_FFFF;
        v.we = 1'b1; v.w_index = 4'd15; v.w_hi = 27'h7FF_FFFF; v.w_g = 1'b0;
        v.w_lo0 = 25'h1FF_FFFF; v.w_lo1 = 25'h1; v.flush = 1'b1; v.fpc = 32'h0000_0000;
        tbl.push_back(v);
        // TLBR at 0 with g=0 and all-ones fields
        v = '0; v.op = 2'd0; v.pc = 32'h0000_0200; v.idx = 32'h0000_0010;
        v.r_hi = {19'h7FFFF, 8'hFF}; v.r_g = 1'b0; v.r_lo0 = 25'h1FF_FFFF; v.r_lo1 = 25'h0;
        v.r_index = 4'd0; v.hilo_we = 1'b1; v.eh = 32'hFFFF_E0FF; v.el0 = 32'h03FF_FFFE;
        v.el1 = 32'h0000_0000; v.flush = 1'b1; v.fpc = 32'h0000_0204;
        tbl.push_back(v);

        // TLBWR issued alongside a Wired write of 10 while Random is 4
        wr = '0; wr.op = 2'd2; wr.pc = 32'h8000_0000; wr.hi = 32'h0000_2001;
        wr.lo0 = 32'h0000_0041; wr.lo1 = 32'h0000_0081; wr.idx = 32'd12;
        wr.we = 1'b1; wr.w_index = 4'd4; wr.w_hi = {19'h1, 8'h01}; wr.w_g = 1'b1;
        wr.w_lo0 = 25'h20; wr.w_lo1 = 25'h40; wr.flush = 1'b1; wr.fpc = 32'h8000_0004;

        resetn = 1'b0; req_valid = 1'b0; req_op = 2'd0; req_pc = '0;
        cp0_entryhi = '0; cp0_entrylo0 = '0; cp0_entrylo1 = '0; cp0_index = '0;
        wired_we = 1'b0; wired_wdata = '0;
        tlb_r_hi = '0; tlb_r_g = 1'b0; tlb_r_lo0 = '0; tlb_r_lo1 = '0;
        tlb_s_found = 1'b0; tlb_s_index = '0;

        repeat (3) @(negedge clk);
        chk("rst_random",    {28'd0, cp0_random}, 32'd15);
        chk("rst_wired",     {28'd0, cp0_wired},  32'd0);
        chk("rst_req_ready", {31'd0, req_ready},  32'd1);
        check_idle_outputs("rst");
        resetn = 1'b1;

        // Idle Random sequence with Wired=0: 15..0 then 15
        model = 4'd15;
        for (int k = 0; k < 21; k++) begin
            chk("idle_random", {28'd0, cp0_random}, {28'd0, model});
            chk("idle_tlb_we", {31'd0, tlb_we}, 32'd0);
            chk("idle_rsp",    {31'd0, rsp_valid}, 32'd0);
            model = (model == 4'd0) ? 4'd15 : model - 4'd1;
            @(negedge clk);
        end

        // Table of ops, issued back-to-back
        for (int i = 0; i < tbl.size(); i++) begin
            issue(tbl[i]);
            finish_op();
        end

        // TLBWR with coincident Wired write
        n = 0;
        while (cp0_random != 4'd4 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("wait_random_4", {28'd0, cp0_random}, 32'd4);
        wired_we    = 1'b1;
        wired_wdata = 4'd10;
        issue(wr);
        finish_op();
        chk("wired_after_write", {28'd0, cp0_wired}, 32'd10);
        model = 4'd13;
        for (int k = 0; k < 11; k++) begin
            chk("wired10_random", {28'd0, cp0_random}, {28'd0, model});
            model = (model == 4'd10) ? 4'd15 : model - 4'd1;
            @(negedge clk);
        end

        // Reset while ACCESS is in flight drops the op
        issue(tbl[0]);
        @(negedge clk);
        req_valid = 1'b0;
        resetn    = 1'b0;
        void'(sb.pop_front());
        #1;
        chk("midrst_random", {28'd0, cp0_random}, 32'd15);
        chk("midrst_wired",  {28'd0, cp0_wired},  32'd0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check_idle_outputs("midrst");
        end
        resetn = 1'b1;
        @(negedge clk);
        check_idle_outputs("post_rst");
        issue(tbl[3]);
        finish_op();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule

// File: doc/tlb_op_ctrl.md
# tlb_op_ctrl

Parametrised TLB-maintenance sequencer sitting beside the writeback stage and the CP0 block. It accepts one TLBR/TLBWI/TLBWR/TLBP per handshake and drives the TLB write, read and search ports. It returns CP0 write-back data and requests a pipeline flush with refetch PC. It extends the fixed 16-entry TLBWI/TLBR/TLBP path with a parametric entry count, a TLBWR instruction with a Random/Wired pair, and a registered multi-cycle datapath.

## Interface
Parameters:
- TLBNUM, 16: TLB entries; power of two, 4..64.
- IDXW, $clog2(TLBNUM): index width.
- WIRED_RST, 0: Wired reset value; must be less than TLBNUM.

Ports (reset: resetn, asynchronous, active-low):
- clk  in  1  clock
- resetn  in  1  asynchronous active-low reset
- req_valid / req_ready  in / out  1 / 1  request handshake
- req_op  in  2  0=TLBR, 1=TLBWI, 2=TLBWR, 3=TLBP
- req_pc  in  32  PC of the TLB instruction
- cp0_entryhi, cp0_entrylo0, cp0_entrylo1, cp0_index  in  32 each  current CP0 values
- wired_we, wired_wdata  in  1, IDXW  mtc0 to Wired
- tlb_we  out  1  TLB write strobe
- tlb_w_index  out  IDXW  TLB write index
- tlb_w_hi  out  27  {vpn2, asid}
- tlb_w_g  out  1  global bit
- tlb_w_lo0, tlb_w_lo1  out  25 each  {pfn, c, d, v}
- tlb_r_index  out  IDXW  TLB read index
- tlb_r_hi, tlb_r_g, tlb_r_lo0, tlb_r_lo1  in  27, 1, 25, 25  TLB read data
- tlb_s_vpn2, tlb_s_asid  out  19, 8  search key
- tlb_s_found, tlb_s_index  in  1, IDXW  search result
- rsp_valid  out  1  one-cycle completion pulse
- hi_lo_we  out  1  write EntryHi/EntryLo0/EntryLo1 (TLBR)
- index_we  out  1  write Index (TLBP)
- entryhi_wdata, entrylo0_wdata, entrylo1_wdata, index_wdata  out  32 each  CP0 write data
- flush_valid, flush_pc  out  1, 32  flush request and refetch PC
- cp0_random, cp0_wired  out  IDXW each  Random and Wired registers

## Operation
- FSM states: IDLE -> ACCESS -> RESP -> IDLE.
- req_ready = 1 only in IDLE.
- On acceptance, latch op, pc, all four CP0 inputs, and the current Random value.
- ACCESS, TLBWI/TLBWR:
  - tlb_we = 1 for one cycle.
  - tlb_w_index = latched Index[IDXW-1:0] (TLBWI) or latched Random (TLBWR).
  - tlb_w_hi = {EntryHi[31:13], EntryHi[7:0]}.
  - tlb_w_g = Lo0[0] & Lo1[0].
  - tlb_w_loN = LoN[25:1].
- ACCESS, TLBR: tlb_r_index = latched Index[IDXW-1:0]; read data is registered at the end of ACCESS.
- ACCESS, TLBP: search key = latched EntryHi vpn2/asid; found/index are registered.
- RESP: rsp_valid = 1.
  - TLBR: hi_lo_we = 1.
    - entryhi_wdata = {vpn2, 5'b0, asid}.
    - entryloN_wdata = {6'b0, pfnN, cN, dN, vN, g}.
  - TLBP: index_we = 1.
    - On hit: index_wdata = zero-extended s_index.
    - On miss: index_wdata = 32'h8000_0000.
  - TLBR/TLBWI/TLBWR: flush_valid = 1 and flush_pc = latched pc + 4. TLBP does not flush.
- Random:
  - Decrements every cycle; when equal to Wired (or Wired >= TLBNUM-1), the next value is TLBNUM-1.
  - Wired write: Wired <= wired_wdata and Random <= TLBNUM-1 the same cycle.
- Wired write coincident with TLBWR acceptance: the TLBWR uses the pre-update Random.
- Unused CP0 write-data outputs are 0 whenever rsp_valid = 0.

## Timing
- Reset (asynchronous, any state): FSM to IDLE, all strobes and data outputs 0, Random = TLBNUM-1, Wired = WIRED_RST. An in-flight op is dropped; no rsp or flush is issued.
- Acceptance at edge 0. tlb_we, tlb_r_index and the search key are valid in cycle 1. rsp_valid and flush_valid are valid in cycle 2.
- Latency is 2 cycles. Throughput is one op per 3 cycles.
- req_ready returns to 1 in cycle 3; back-to-back ops are accepted at edges 0, 3, 6.
- All outputs are registered or decoded from the state register only. TLB inputs are combinational with respect to the driven index/key.

## Test plan
- Reset, then idle 20 cycles with TLBNUM=16, Wired=0 -> Random sequence 15, 14, …, 0, 15. All strobes stay 0.
- TLBWI: Index=5, EntryHi=32'h1234_A0FF, Lo0=32'h0000_0047, Lo1=32'h0000_0087 -> cycle 1 tlb_we=1, w_index=5, w_hi={19'h091A5, 8'hFF}, w_g=1. Cycle 2 flush_pc=req_pc+4.
- TLBP miss (s_found=0) -> index_we=1, index_wdata=32'h8000_0000, flush_valid=0. TLBP hit at 9 -> index_wdata=9.
- TLBR at Index 3 returning vpn2=19'h7, asid=8'h2, g=1 -> entryhi_wdata=32'h0000_E002, hi_lo_we=1, flush_valid=1.
- Wired write of 10 coinciding with TLBWR acceptance while Random=4 -> TLBWR writes index 4. Random then cycles 15..10 only.
- resetn asserted during ACCESS -> no rsp_valid or flush_valid. Next request completes normally.
